// File: rtl/spi_frame_ctrl_pkg.sv
// spi_frame_ctrl_pkg: shared constants and types for the SPI frame sequencer.
//   ClkFreq          - system clock frequency shared with the rest of the design
//   SpiSt*           - 2-bit state encodings of the frame FSM
//   spi_state_e      - typed FSM state built on those encodings
package spi_frame_ctrl_pkg;

  localparam int unsigned ClkFreq = 50_000_000;

  localparam logic [1:0] SpiStIdle  = 2'd0;
  localparam logic [1:0] SpiStLoad  = 2'd1;
  localparam logic [1:0] SpiStShift = 2'd2;
  localparam logic [1:0] SpiStGap   = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = SpiStIdle,
    StLoad  = SpiStLoad,
    StShift = SpiStShift,
    StGap   = SpiStGap
  } spi_state_e;

endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous single-clock byte FIFO.
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset (empties the FIFO)
//   push, din      - write request and data; dropped while full, even alongside a pop
//   pop            - remove the head entry; ignored while empty
//   dout           - current head entry (read from the register array)
//   full, empty    - occupancy flags
//   level          - occupancy, 0..DEPTH
module spi_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   level_q;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (level_q == (PtrW + 1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: frame sequencer in front of the byte-serial SPI transmitter.
// Bytes are buffered in a FIFO; `start` sends `frame_len` of them as one CS frame,
// holding spi_onoff high, presenting each byte on spi_data and advancing on spi_valid,
// then keeps CS low for GAP_CYCLES before pulsing `done`.
// Optional build macro: SPI_TIMEOUT_EN adds a per-byte watchdog (TIMEOUT_CYCLES) that
// aborts a stalled frame, discards its remaining bytes and still finishes with the gap.
// Ports:
//   clk, reset_n        - clock, synchronous active-low reset
//   wr_en, wr_data      - FIFO write
//   full, level         - FIFO status
//   start, frame_len    - frame request (frame_len sampled with start)
//   busy, done, err     - status; done/err are one-cycle pulses
//   spi_onoff, spi_data - transmitter onoff / data_in
//   spi_valid           - transmitter byte-complete pulse
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  input  logic                          start,
  input  logic [$clog2(FIFO_DEPTH):0]   frame_len,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          spi_onoff,
  output logic [7:0]                    spi_data,
  input  logic                          spi_valid
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  spi_state_e      state_q;
  logic [LvlW-1:0] bytes_left_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_empty;
  logic            more_bytes;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0]  wd_cnt_q;
  logic            drain_q;
`endif

  assign more_bytes = (bytes_left_q != '0);

  spi_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .din     (wr_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Pop happens in the same cycle the byte is captured into spi_data.
  always_comb begin
    fifo_pop = 1'b0;
    unique case (state_q)
      StLoad:  fifo_pop = 1'b1;
      StShift: begin
`ifdef SPI_TIMEOUT_EN
        if (drain_q) fifo_pop = more_bytes;
        else
`endif
        fifo_pop = spi_valid && more_bytes;
      end
      default: fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bytes_left_q <= '0;
      gap_cnt_q    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      spi_onoff    <= 1'b0;
      spi_data     <= '0;
`ifdef SPI_TIMEOUT_EN
      wd_cnt_q     <= '0;
      drain_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (frame_len != '0 && frame_len <= level && !fifo_empty) begin
              bytes_left_q <= frame_len;
              busy         <= 1'b1;
              state_q      <= StLoad;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StLoad: begin
          spi_data     <= fifo_dout;
          spi_onoff    <= 1'b1;
          bytes_left_q <= bytes_left_q - LvlW'(1);
          state_q      <= StShift;
`ifdef SPI_TIMEOUT_EN
          wd_cnt_q     <= '0;
`endif
        end
        StShift: begin
`ifdef SPI_TIMEOUT_EN
          if (drain_q) begin
            // Aborted frame: discard what is left, then run the normal gap.
            if (more_bytes) begin
              bytes_left_q <= bytes_left_q - LvlW'(1);
            end else begin
              drain_q   <= 1'b0;
              gap_cnt_q <= GapW'(GAP_CYCLES - 1);
              state_q   <= StGap;
            end
          end else if (!spi_valid) begin
            if (wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1)) begin
              spi_onoff <= 1'b0;
              err       <= 1'b1;
              drain_q   <= 1'b1;
            end else begin
              wd_cnt_q <= wd_cnt_q + WdW'(1);
            end
          end else begin
            wd_cnt_q <= '0;
          end
          if (spi_valid && !drain_q) begin
`else
          if (spi_valid) begin
`endif
            if (more_bytes) begin
              spi_data     <= fifo_dout;
              bytes_left_q <= bytes_left_q - LvlW'(1);
            end else begin
              spi_onoff <= 1'b0;
              gap_cnt_q <= GapW'(GAP_CYCLES - 1);
              state_q   <= StGap;
            end
          end
        end
        StGap: begin
          // Counter starts at GAP_CYCLES-1 so CS stays low for exactly GAP_CYCLES cycles.
          if (gap_cnt_q == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - GapW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed, self-checking bench for spi_frame_ctrl (default build).
// Written bytes go into a scoreboard queue; each byte the DUT presents is checked
// against the queue head, alongside CS framing, gap length, err and FIFO status.
module tb_spi_frame_ctrl;

  localparam int unsigned Depth = 16;
  localparam int unsigned Gap   = 100;
  localparam int unsigned Lw    = $clog2(Depth) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [Lw-1:0] level;
  logic          start;
  logic [Lw-1:0] frame_len;
  logic          busy;
  logic          done;
  logic          err;
  logic          spi_onoff;
  logic [7:0]    spi_data;
  logic          spi_valid;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         mlevel   = 0;
  logic [7:0] sb[$];

  spi_frame_ctrl #(
    .FIFO_DEPTH     (Depth),
    .GAP_CYCLES     (Gap),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .level     (level),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .spi_onoff (spi_onoff),
    .spi_data  (spi_data),
    .spi_valid (spi_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (mlevel < Depth) begin
      sb.push_back(b);
      mlevel++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  // Transmitter model: spi_valid every 8 cycles per byte.
  task automatic send_frame(input int len, input bit inject, input bit do_reset);
    logic [7:0] exp;
    bit         cs_ok;
    int         n;
    cs_ok     = 1'b1;
    start     = 1'b1;
    frame_len = len[Lw-1:0];
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    tick();
    exp = sb.pop_front();
    mlevel--;
    check("cs_rise", 32'(spi_onoff), 1);
    check("first_byte", 32'(spi_data), 32'(exp));
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 7; c++) begin
        if (inject && i == 0 && c == 3) begin
          wr_en     = 1'b1;
          wr_data   = 8'h55;
          start     = 1'b1;
          frame_len = Lw'(1);
          sb.push_back(8'h55);
          mlevel++;
        end
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        if (spi_onoff !== 1'b1) cs_ok = 1'b0;
        if (err !== 1'b0) cs_ok = 1'b0;
      end
      spi_valid = 1'b1;
      tick();
      spi_valid = 1'b0;
      if (do_reset && i == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_cs", 32'(spi_onoff), 0);
        check("rst_data", 32'(spi_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(busy), 0);
        sb.delete();
        mlevel = 0;
        n = 0;
        repeat (Gap + 20) begin
          tick();
          if (done) n++;
        end
        check("rst_no_done", 32'(n), 0);
        return;
      end
      if (i < len - 1) begin
        exp = sb.pop_front();
        mlevel--;
        check("next_byte", 32'(spi_data), 32'(exp));
      end else begin
        check("cs_fall", 32'(spi_onoff), 0);
        check("data_hold", 32'(spi_data), 32'(exp));
      end
    end
    check("cs_continuous", 32'(cs_ok), 1);
    n = 0;
    while (!done && n < Gap + 50) begin
      tick();
      n++;
    end
    check("gap_len", 32'(n), Gap);
    check("done_busy", 32'(busy), 0);
    tick();
    check("done_pulse", 32'(done), 0);
    check("level_after", 32'(level), 32'(mlevel));
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    start     = 1'b0;
    frame_len = '0;
    spi_valid = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 0);
    check("reset_onoff", 32'(spi_onoff), 0);
    check("reset_data", 32'(spi_data), 0);
    check("reset_done", 32'(done), 0);
    check("reset_err", 32'(err), 0);
    check("reset_full", 32'(full), 0);
    check("reset_level", 32'(level), 0);
    reset_n = 1'b1;
    tick();

    // Basic 3-byte frame.
    wr(8'hA5);
    wr(8'h3C);
    wr(8'h81);
    check("level_3", 32'(level), 3);
    send_frame(3, 1'b0, 1'b0);

    // Rejected starts: too long, then zero length.
    wr(8'h11);
    wr(8'h22);
    start     = 1'b1;
    frame_len = Lw'(3);
    tick();
    start = 1'b0;
    check("err_too_long", 32'(err), 1);
    check("err_busy", 32'(busy), 0);
    tick();
    check("err_pulse", 32'(err), 0);
    check("err_level", 32'(level), 2);
    start     = 1'b1;
    frame_len = '0;
    tick();
    start = 1'b0;
    check("err_zero", 32'(err), 1);
    check("err_zero_busy", 32'(busy), 0);
    tick();
    send_frame(2, 1'b0, 1'b0);

    // Fill past capacity; 17th write dropped; frame crosses pointer wrap.
    for (int i = 0; i < 17; i++) begin
      wr(8'(i * 7 + 3));
      if (i == 14) check("not_full_15", 32'(full), 0);
      if (i == 15) begin
        check("full_16", 32'(full), 1);
        check("level_16", 32'(level), 16);
      end
    end
    check("level_after_17", 32'(level), 16);
    check("full_after_17", 32'(full), 1);
    send_frame(16, 1'b0, 1'b0);

    // Write and start during SHIFT: start ignored, new byte stays queued.
    wr(8'h66);
    wr(8'h77);
    send_frame(2, 1'b1, 1'b0);
    check("inject_level", 32'(level), 1);

    // Reset after the first valid of a frame.
    wr(8'h99);
    send_frame(2, 1'b0, 1'b1);

    // Block still works after the mid-frame reset.
    wr(8'hC3);
    send_frame(1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
